// File: rtl/cache_pkg.sv
// Shared types and constants for the cache refill controller and its fill buffer.
package cache_pkg;

  localparam int WORD_W        = 32;
  localparam int WORDS_PER_BLK = 4;
  localparam int OFFSET_W      = 2;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    REFILL,
    FILL,
    RESP,
    INV
  } state_e;

  typedef logic [WORDS_PER_BLK*WORD_W-1:0] line_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    return (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

endpackage

// File: rtl/cache_fill_buffer.sv
// Collects the memory words of one refill into a full cache line, one word per acknowledged beat.
module cache_fill_buffer
  import cache_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clear_i,
  input  logic                capture_i,
  input  logic [WORD_W-1:0]   word_i,
  output logic [OFFSET_W-1:0] beat_o,
  output logic                last_o,
  output line_t               line_o
);

  logic [OFFSET_W-1:0] beat_q, beat_d;
  line_t               line_q, line_d;

  // The beat counter wraps to zero after the final word, so no explicit reset is needed after a fill.
  always_comb begin
    beat_d = beat_q;
    line_d = line_q;
    if (clear_i) begin
      beat_d = '0;
    end else if (capture_i) begin
      line_d[int'(beat_q)*WORD_W +: WORD_W] = word_i;
      beat_d = beat_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q <= '0;
      line_q <= '0;
    end else begin
      beat_q <= beat_d;
      line_q <= line_d;
    end
  end

  assign beat_o = beat_q;
  assign last_o = (beat_q == OFFSET_W'(WORDS_PER_BLK - 1));
  assign line_o = line_q;

endmodule

// File: rtl/cache_refill_ctrl.sv
// Read/refill/invalidate sequencer for the direct-mapped 4-word-block cache array.
// Define CACHE_STATS_EN to add saturating hit_cnt/miss_cnt outputs.
module cache_refill_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cpu_req,
  input  logic [ADDR_W-1:0]          cpu_addr,
  input  logic                       inv_req,
  output logic                       cpu_ready,
  output logic [WORD_W-1:0]          cpu_rdata,
  output logic [ADDR_W-1:0]          cache_addr,
  input  logic                       cache_hit,
  input  logic [WORD_W-1:0]          cache_rdata,
  output logic                       fill_en,
  output logic [WORDS_PER_BLK*WORD_W-1:0] fill_line,
  output logic                       inv_en,
  output logic                       mem_req,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic                       mem_ack,
  input  logic [WORD_W-1:0]          mem_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]                hit_cnt,
  output logic [15:0]                miss_cnt
`endif
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   rdata_q, rdata_d;
  logic [OFFSET_W-1:0] beat;
  logic                lastBeat;
  logic                clearBeat;
  logic                capture;
  line_t               line;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
    end
  end

  // Invalidate wins over a read in IDLE; the held read is picked up on the return to IDLE.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (inv_req) begin
          addr_d  = cpu_addr;
          state_d = INV;
        end else if (cpu_req) begin
          addr_d  = cpu_addr;
          state_d = LOOKUP;
        end
      end
      INV:    state_d = IDLE;
      LOOKUP: begin
        if (cache_hit) begin
          rdata_d = cache_rdata;
          state_d = RESP;
        end else begin
          state_d = REFILL;
        end
      end
      REFILL: if (mem_ack && lastBeat) state_d = FILL;
      FILL:   state_d = LOOKUP;
      RESP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cpu_ready = 1'b0;
    fill_en   = 1'b0;
    inv_en    = 1'b0;
    mem_req   = 1'b0;
    clearBeat = 1'b0;
    capture   = 1'b0;
    case (state_q)
      INV:    inv_en = 1'b1;
      LOOKUP: clearBeat = !cache_hit;
      REFILL: begin
        mem_req = 1'b1;
        capture = mem_ack;
      end
      FILL:   fill_en = 1'b1;
      RESP:   cpu_ready = 1'b1;
      default: ;
    endcase
  end

  cache_fill_buffer u_fill_buffer (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (clearBeat),
    .capture_i (capture),
    .word_i    (mem_rdata),
    .beat_o    (beat),
    .last_o    (lastBeat),
    .line_o    (line)
  );

  assign cache_addr = addr_q;
  assign mem_addr   = {addr_q[ADDR_W-1:OFFSET_W], beat};
  assign cpu_rdata  = rdata_q;
  assign fill_line  = line;

`ifdef CACHE_STATS_EN
  logic        reLookup_q;
  logic [15:0] hitCnt_q;
  logic [15:0] missCnt_q;

  // The lookup right after FILL always hits by construction, so it is not a real hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      reLookup_q <= 1'b0;
      hitCnt_q   <= '0;
      missCnt_q  <= '0;
    end else begin
      reLookup_q <= (state_q == FILL);
      if (state_q == LOOKUP && cache_hit && !reLookup_q) hitCnt_q <= sat_inc16(hitCnt_q);
      if (state_q == LOOKUP && !cache_hit) missCnt_q <= sat_inc16(missCnt_q);
    end
  end

  assign hit_cnt  = hitCnt_q;
  assign miss_cnt = missCnt_q;
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed self-checking bench for cache_refill_ctrl with a behavioural cache array and memory.
module tb_cache_refill_ctrl;

  logic          clk;
  logic          rst;
  logic          cpu_req;
  logic [14:0]   cpu_addr;
  logic          inv_req;
  logic          cpu_ready;
  logic [31:0]   cpu_rdata;
  logic [14:0]   cache_addr;
  logic          cache_hit;
  logic [31:0]   cache_rdata;
  logic          fill_en;
  logic [127:0]  fill_line;
  logic          inv_en;
  logic          mem_req;
  logic [14:0]   mem_addr;
  logic          mem_ack;
  logic [31:0]   mem_rdata;
`ifdef CACHE_STATS_EN
  logic [15:0]   hit_cnt;
  logic [15:0]   miss_cnt;
`endif

  cache_refill_ctrl #(.ADDR_W(15)) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_req     (cpu_req),
    .cpu_addr    (cpu_addr),
    .inv_req     (inv_req),
    .cpu_ready   (cpu_ready),
    .cpu_rdata   (cpu_rdata),
    .cache_addr  (cache_addr),
    .cache_hit   (cache_hit),
    .cache_rdata (cache_rdata),
    .fill_en     (fill_en),
    .fill_line   (fill_line),
    .inv_en      (inv_en),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata)
`ifdef CACHE_STATS_EN
    ,
    .hit_cnt     (hit_cnt),
    .miss_cnt    (miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Direct-mapped array model: index addr[5:2], tag addr[14:6].
  logic         valid [16];
  logic [8:0]   tagA  [16];
  logic [127:0] dataA [16];
  logic [3:0]   idx;
  logic [127:0] curLine;

  assign idx         = cache_addr[5:2];
  assign curLine     = dataA[idx];
  assign cache_hit   = valid[idx] && (tagA[idx] == cache_addr[14:6]);
  assign cache_rdata = curLine[32*cache_addr[1:0] +: 32];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) valid[i] <= 1'b0;
    end else begin
      if (fill_en) begin
        valid[idx] <= 1'b1;
        tagA[idx]  <= cache_addr[14:6];
        dataA[idx] <= fill_line;
      end
      if (inv_en) valid[idx] <= 1'b0;
    end
  end

  // Memory responder: word at address a is a + 0x0C, acked after memWait idle cycles.
  int memWait;
  int waitCnt;

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    waitCnt   = 0;
    forever begin
      @(negedge clk);
      if (mem_req && !rst) begin
        if (waitCnt < memWait) begin
          mem_ack = 1'b0;
          waitCnt++;
        end else begin
          mem_ack   = 1'b1;
          mem_rdata = 32'(mem_addr) + 32'h0C;
          waitCnt   = 0;
        end
      end else begin
        mem_ack = 1'b0;
        waitCnt = 0;
      end
    end
  end

  // Event monitor sampling the pre-edge values seen by the DUT.
  int           beatsTaken = 0;
  int           fillCount  = 0;
  int           invCount   = 0;
  int           reqCycles  = 0;
  int           addrJumps  = 0;
  logic [127:0] lastFillLine = '0;
  logic [14:0]  memLog[$];
  logic         prevReq  = 1'b0;
  logic         prevAck  = 1'b0;
  logic [14:0]  prevAddr = '0;

  always @(posedge clk) begin
    if (!rst) begin
      if (mem_req && mem_ack) begin
        beatsTaken++;
        memLog.push_back(mem_addr);
      end
      if (mem_req) reqCycles++;
      if (mem_req && prevReq && !prevAck && mem_addr != prevAddr) addrJumps++;
      if (fill_en) begin
        fillCount++;
        lastFillLine = fill_line;
      end
      if (inv_en) invCount++;
    end
    prevReq  = mem_req && !rst;
    prevAck  = mem_ack;
    prevAddr = mem_addr;
  end

  int passCount  = 0;
  int totalCount = 0;

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    totalCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  // One read transaction; cycles counts from the accepting IDLE cycle through the cpu_ready cycle.
  task automatic applyStimulus(input logic [14:0] addr, input bit withInv,
                               output logic [31:0] data, output int cycles);
    bit done;
    @(negedge clk);
    cpu_addr = addr;
    cpu_req  = 1'b1;
    inv_req  = withInv;
    cycles   = 1;
    done     = 1'b0;
    data     = '0;
    for (int i = 0; i < 80 && !done; i++) begin
      @(negedge clk);
      inv_req = 1'b0;
      cycles++;
      if (cpu_ready) begin
        done    = 1'b1;
        data    = cpu_rdata;
        cpu_req = 1'b0;
      end
    end
    cpu_req = 1'b0;
    checkOutput("readDone", 128'(done), 128'd1);
  endtask

  logic [31:0] rdata;
  int          cycles;
  int          logBase, fill0, inv0, beats0, req0, jump0;
  bit          reached;
`ifdef CACHE_STATS_EN
  logic [15:0] hit0, miss0;
`endif

  initial begin
    rst      = 1'b1;
    cpu_req  = 1'b0;
    cpu_addr = '0;
    inv_req  = 1'b0;
    memWait  = 0;
    repeat (2) @(negedge clk);

    checkOutput("rstReady",   128'(cpu_ready),  128'd0);
    checkOutput("rstFillEn",  128'(fill_en),    128'd0);
    checkOutput("rstInvEn",   128'(inv_en),     128'd0);
    checkOutput("rstMemReq",  128'(mem_req),    128'd0);
    checkOutput("rstRdata",   128'(cpu_rdata),  128'd0);
    checkOutput("rstLine",    fill_line,        128'd0);
    checkOutput("rstMemAddr", 128'(mem_addr),   128'd0);
    checkOutput("rstCacheAd", 128'(cache_addr), 128'd0);
`ifdef CACHE_STATS_EN
    checkOutput("rstHitCnt",  128'(hit_cnt),  128'd0);
    checkOutput("rstMissCnt", 128'(miss_cnt), 128'd0);
`endif
    rst = 1'b0;

    // Cold read of 0x0005: refill block 0x4..0x7 with words 0x10..0x13.
    logBase = memLog.size();
    fill0   = fillCount;
    applyStimulus(15'h0005, 1'b0, rdata, cycles);
    checkOutput("coldRdata",  128'(rdata), 128'h11);
    checkOutput("coldCycles", 128'(cycles), 128'd9);
    checkOutput("coldBeats",  128'(memLog.size() - logBase), 128'd4);
    for (int i = 0; i < 4; i++) checkOutput("coldAddr", 128'(memLog[logBase + i]), 128'(4 + i));
    checkOutput("coldFills", 128'(fillCount - fill0), 128'd1);
    checkOutput("coldLine",  lastFillLine, {32'h13, 32'h12, 32'h11, 32'h10});

    // Repeat read in the same block: hit, no memory traffic.
    beats0 = beatsTaken;
    fill0  = fillCount;
    applyStimulus(15'h0006, 1'b0, rdata, cycles);
    checkOutput("hitRdata",  128'(rdata), 128'h12);
    checkOutput("hitCycles", 128'(cycles), 128'd3);
    checkOutput("hitBeats",  128'(beatsTaken - beats0), 128'd0);
    checkOutput("hitFills",  128'(fillCount - fill0), 128'd0);

    // Two wait cycles per beat: mem_req stays up 12 cycles and the address only moves on ack.
    memWait = 2;
    logBase = memLog.size();
    req0    = reqCycles;
    jump0   = addrJumps;
    applyStimulus(15'h0013, 1'b0, rdata, cycles);
    checkOutput("waitRdata",  128'(rdata), 128'h1F);
    checkOutput("waitCycles", 128'(cycles), 128'd17);
    checkOutput("waitReqCyc", 128'(reqCycles - req0), 128'd12);
    checkOutput("waitJumps",  128'(addrJumps - jump0), 128'd0);
    for (int i = 0; i < 4; i++) checkOutput("waitAddr", 128'(memLog[logBase + i]), 128'(16 + i));
    checkOutput("waitLine", lastFillLine, {32'h1F, 32'h1E, 32'h1D, 32'h1C});
    memWait = 0;

    // Invalidate and read together: invalidate first, then the read misses and refills.
    inv0    = invCount;
    logBase = memLog.size();
    applyStimulus(15'h0006, 1'b1, rdata, cycles);
    checkOutput("invCount",  128'(invCount - inv0), 128'd1);
    checkOutput("invCycles", 128'(cycles), 128'd11);
    checkOutput("invBeats",  128'(memLog.size() - logBase), 128'd4);
    checkOutput("invRdata",  128'(rdata), 128'h12);

    // Reset after two beats of a refill aborts it.
    beats0 = beatsTaken;
    fill0  = fillCount;
    @(negedge clk);
    cpu_addr = 15'h0009;
    cpu_req  = 1'b1;
    reached  = 1'b0;
    for (int i = 0; i < 40 && !reached; i++) begin
      @(negedge clk);
      if (beatsTaken - beats0 == 2) reached = 1'b1;
    end
    checkOutput("abortReach", 128'(reached), 128'd1);
    rst     = 1'b1;
    cpu_req = 1'b0;
    @(negedge clk);
    checkOutput("abortMemReq", 128'(mem_req), 128'd0);
    checkOutput("abortFillEn", 128'(fill_en), 128'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("abortFills", 128'(fillCount - fill0), 128'd0);
    checkOutput("abortBeats", 128'(beatsTaken - beats0), 128'd2);
    logBase = memLog.size();
    applyStimulus(15'h0009, 1'b0, rdata, cycles);
    checkOutput("retryBeats", 128'(memLog.size() - logBase), 128'd4);
    for (int i = 0; i < 4; i++) checkOutput("retryAddr", 128'(memLog[logBase + i]), 128'(8 + i));
    checkOutput("retryRdata", 128'(rdata), 128'h15);
    checkOutput("retryFills", 128'(fillCount - fill0), 128'd1);

`ifdef CACHE_STATS_EN
    // One cold read plus three repeats in block 0x20.
    hit0  = hit_cnt;
    miss0 = miss_cnt;
    applyStimulus(15'h0021, 1'b0, rdata, cycles);
    applyStimulus(15'h0022, 1'b0, rdata, cycles);
    applyStimulus(15'h0023, 1'b0, rdata, cycles);
    applyStimulus(15'h0020, 1'b0, rdata, cycles);
    checkOutput("statsRdata", 128'(rdata), 128'h2C);
    checkOutput("statsMiss",  128'(miss_cnt - miss0), 128'd1);
    checkOutput("statsHit",   128'(hit_cnt - hit0), 128'd3);
`endif

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
Sequencing controller for the direct-mapped, 4-word-block instruction/data cache array.
- Accepts CPU read requests and drives the array lookup.
- On a miss, stalls the CPU and fetches the 4-word block from main memory one word per handshake, then writes the assembled line into the array.
- Also sequences single-line invalidate requests.
- Sits between the CPU memory stage, the cache array and the main-memory port.

Parameters:
ADDR_W, 15, word address width; bits [1:0] are the word-in-block offset.
WORD_W, 32, data word width.
WORDS_PER_BLK, 4, words per cache line; fixed at 4, so the beat counter is 2 bits.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
cpu_req  in  1  read request; held by CPU until cpu_ready
cpu_addr  in  ADDR_W  read word address
inv_req  in  1  invalidate line of cpu_addr (1-cycle pulse)
cpu_ready  out  1  1-cycle pulse: cpu_rdata valid, request complete
cpu_rdata  out  WORD_W  read data, registered
cache_addr  out  ADDR_W  lookup/fill/invalidate address to array
cache_hit  in  1  array hit for cache_addr (combinational from array)
cache_rdata  in  WORD_W  array word for cache_addr
fill_en  out  1  1-cycle line write strobe
fill_line  out  4*WORD_W  assembled line; word i at bits [32i+31:32i]
inv_en  out  1  1-cycle clear-valid strobe
mem_req  out  1  memory read request, held until mem_ack
mem_addr  out  ADDR_W  beat address = {block base, beat[1:0]}
mem_ack  in  1  memory word valid this cycle
mem_rdata  in  WORD_W  memory word

Behaviour:
- Reset: state IDLE, beat=0, addr_q=0. cpu_ready, fill_en, inv_en and mem_req are 0. cpu_rdata, fill_line and mem_addr are all-zero.
- cache_addr = addr_q in every state.
- IDLE:
  - inv_req=1: latch cpu_addr, go to INV. inv_req has priority over cpu_req in the same cycle; the read is taken next cycle because cpu_req is still held.
  - Else cpu_req=1: latch cpu_addr into addr_q, go to LOOKUP.
- INV: inv_en=1 for one cycle, then IDLE.
- LOOKUP:
  - cache_hit=1: register cpu_rdata<=cache_rdata, go to RESP.
  - cache_hit=0: beat<=0, go to REFILL.
  - Hit latency: cpu_ready asserts 3 cycles after the request is accepted in IDLE.
- REFILL:
  - mem_req=1, mem_addr={addr_q[ADDR_W-1:2], beat}.
  - On mem_ack, capture mem_rdata into word[beat] and increment beat.
  - mem_req stays high between beats. Memory is sampled only on mem_ack; zero-wait memory completes one beat per cycle.
  - On the 4th ack (beat==3): beat wraps to 0, go to FILL.
- FILL: fill_en=1 with fill_line for one cycle, then LOOKUP. The re-lookup must hit; cpu_rdata therefore always comes from the array.
- RESP: cpu_ready=1 for one cycle, then IDLE. A new cpu_req is accepted no earlier than the following cycle.
- Busy states (all except IDLE):
  - cpu_req and inv_req are ignored; a pulsed inv_req arriving while busy is dropped.
  - mem_ack outside REFILL is ignored.
- Reset mid-refill: abort. mem_req is 0 the next cycle, the partial line is discarded and no fill_en is issued.
- Miss penalty: 4 beats plus 2 cycles (FILL, LOOKUP) over a hit.

Optional Feature:
CACHE_STATS_EN
- With the macro: adds outputs hit_cnt[15:0] and miss_cnt[15:0]. Both reset to 0.
  - hit_cnt increments on a LOOKUP hit that is not the post-FILL re-lookup.
  - miss_cnt increments on a LOOKUP miss.
  - Both saturate at 16'hFFFF.
- Without the macro: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package cache_pkg: WORD_W, WORDS_PER_BLK, OFFSET_W=2, state enum {IDLE, LOOKUP, REFILL, FILL, RESP, INV}, line typedef (logic [4*WORD_W-1:0]).
- One sub-module, cache_fill_buffer: beat counter, word capture on ack, last-beat flag, fill_line register. The controller FSM instantiates it.

Test Plan:
- Cold read addr 0x0005 with memory words 0x10..0x13 at 0x0004..0x0007 -> 4 mem beats at 0x0004..0x0007, fill_en once, cpu_ready with cpu_rdata=0x11.
- Repeat read 0x0006 -> no mem_req, cpu_ready 3 cycles after accept, cpu_rdata=0x12.
- Memory with 2 wait cycles per beat, mem_ack deasserted between beats -> mem_req held continuously, mem_addr advances only on ack, fill_line correct.
- inv_req and cpu_req together at 0x0006 -> inv_en first, then the read misses and refills.
- rst asserted after 2 beats of a refill -> mem_req=0 next cycle, no fill_en; a later read of the same block refills all 4 beats.
- CACHE_STATS_EN: 1 cold read plus 3 repeats of the same block -> miss_cnt=1, hit_cnt=3.
